core_data_axi4l_bridge: RTL

- Downstream stage of the core data-side interconnect: takes the decoder port selected for off-chip/peripheral space and converts CV32E OBI-style data requests into single AXI4-Lite master transactions.
- Exactly one transaction outstanding at a time; responses are returned to the core as a one-cycle rvalid pulse.
- Sits between the data decoder port and the SoC AXI4-Lite peripheral fabric.

---
 rtl/core_data_axi4l_bridge.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/core_data_axi4l_bridge.sv
// core_data_axi4l_bridge: OBI data port to a single-outstanding AXI4-Lite master.
// Optional slave timeout with response drain: define CORE_DATA_AXI4L_TIMEOUT_EN.
module core_data_axi4l_bridge #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [2:0]  PROT_VALUE = 3'b000
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  req_i,
   output logic                  gnt_o,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  we_i,
   input  logic [3:0]            be_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  err_o,
   output logic [ADDR_WIDTH-1:0] m_awaddr_o,
   output logic [2:0]            m_awprot_o,
   output logic                  m_awvalid_o,
   input  logic                  m_awready_i,
   output logic [DATA_WIDTH-1:0] m_wdata_o,
   output logic [3:0]            m_wstrb_o,
   output logic                  m_wvalid_o,
   input  logic                  m_wready_i,
   input  logic [1:0]            m_bresp_i,
   input  logic                  m_bvalid_i,
   output logic                  m_bready_o,
   output logic [ADDR_WIDTH-1:0] m_araddr_o,
   output logic [2:0]            m_arprot_o,
   output logic                  m_arvalid_o,
   input  logic                  m_arready_i,
   input  logic [DATA_WIDTH-1:0] m_rdata_i,
   input  logic [1:0]            m_rresp_i,
   input  logic                  m_rvalid_i,
   output logic                  m_rready_o
);

   if (DATA_WIDTH != 32) begin : g_dw_check
      $error("core_data_axi4l_bridge: DATA_WIDTH must be 32");
   end

`ifdef CORE_DATA_AXI4L_TIMEOUT_EN
   typedef enum logic [2:0] {
      IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP, DRAIN
   } state_e;
`else
   typedef enum logic [2:0] {
      IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP
   } state_e;
`endif

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [3:0]            be_q;
   logic                  awvalid_q;
   logic                  wvalid_q;
   logic                  arvalid_q;
   logic                  bready_q;
   logic                  rready_q;
   logic                  rvalid_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic aw_done;
   logic w_done;
   logic b_err;
   logic r_err;

`ifdef CORE_DATA_AXI4L_TIMEOUT_EN
   logic [15:0] cnt_q;
   logic        to_q;
   logic        drain_wr_q;
   logic        busy;
   logic        timeout;

   // Slave is considered hung once the wait counter saturates.
   assign busy    = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                    (state_q == RD_REQ) || (state_q == RD_RESP);
   assign timeout = busy && (cnt_q == 16'hFFFF);
`endif

   // A channel is finished once its valid is low or accepted now.
   assign aw_done = !awvalid_q || m_awready_i;
   assign w_done  = !wvalid_q  || m_wready_i;

   // SLVERR and DECERR are errors; OKAY and EXOKAY are not.
   assign b_err = (m_bresp_i == 2'b10) || (m_bresp_i == 2'b11);
   assign r_err = (m_rresp_i == 2'b10) || (m_rresp_i == 2'b11);

   assign gnt_o       = req_i && (state_q == IDLE);
   assign rvalid_o    = rvalid_q;
   assign rdata_o     = rdata_q;
   assign err_o       = err_q;
   assign m_awaddr_o  = addr_q;
   assign m_araddr_o  = addr_q;
   assign m_awprot_o  = PROT_VALUE;
   assign m_arprot_o  = PROT_VALUE;
   assign m_awvalid_o = awvalid_q;
   assign m_wdata_o   = wdata_q;
   assign m_wstrb_o   = be_q;
   assign m_wvalid_o  = wvalid_q;
   assign m_bready_o  = bready_q;
   assign m_arvalid_o = arvalid_q;
   assign m_rready_o  = rready_q;

   // Transaction FSM; every AXI and response output is a register here.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         bready_q  <= 1'b0;
         rready_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
`ifdef CORE_DATA_AXI4L_TIMEOUT_EN
         cnt_q      <= '0;
         to_q       <= 1'b0;
         drain_wr_q <= 1'b0;
`endif
      end else begin
`ifdef CORE_DATA_AXI4L_TIMEOUT_EN
         if (busy) begin
            cnt_q <= cnt_q + 16'd1;
         end
`endif
         unique case (state_q)
            IDLE: begin
               if (req_i) begin
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
                  be_q    <= be_i;
`ifdef CORE_DATA_AXI4L_TIMEOUT_EN
                  cnt_q   <= '0;
`endif
                  if (we_i) begin
                     state_q   <= WR_REQ;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                  end else begin
                     state_q   <= RD_REQ;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            WR_REQ: begin
               if (awvalid_q && m_awready_i) begin
                  awvalid_q <= 1'b0;
               end
               if (wvalid_q && m_wready_i) begin
                  wvalid_q <= 1'b0;
               end
               if (aw_done && w_done) begin
                  state_q  <= WR_RESP;
                  bready_q <= 1'b1;
               end
            end
            WR_RESP: begin
               if (m_bvalid_i) begin
                  bready_q <= 1'b0;
                  err_q    <= b_err;
                  rvalid_q <= 1'b1;
                  state_q  <= RESP;
               end
            end
            RD_REQ: begin
               if (m_arready_i) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (m_rvalid_i) begin
                  rready_q <= 1'b0;
                  rdata_q  <= m_rdata_i;
                  err_q    <= r_err;
                  rvalid_q <= 1'b1;
                  state_q  <= RESP;
               end
            end
            RESP: begin
               rvalid_q <= 1'b0;
`ifdef CORE_DATA_AXI4L_TIMEOUT_EN
               if (to_q) begin
                  state_q  <= DRAIN;
                  bready_q <= drain_wr_q;
                  rready_q <= !drain_wr_q;
               end else begin
                  state_q <= IDLE;
               end
`else
               state_q <= IDLE;
`endif
            end
`ifdef CORE_DATA_AXI4L_TIMEOUT_EN
            DRAIN: begin
               if ((bready_q && m_bvalid_i) ||
                   (rready_q && m_rvalid_i)) begin
                  bready_q <= 1'b0;
                  rready_q <= 1'b0;
                  to_q     <= 1'b0;
                  state_q  <= IDLE;
               end
            end
`endif
            default: begin
               state_q <= IDLE;
            end
         endcase
`ifdef CORE_DATA_AXI4L_TIMEOUT_EN
         if (timeout) begin
            state_q    <= RESP;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            bready_q   <= 1'b0;
            rready_q   <= 1'b0;
            rvalid_q   <= 1'b1;
            err_q      <= 1'b1;
            rdata_q    <= DATA_WIDTH'(32'hDEAD_BEEF);
            to_q       <= 1'b1;
            drain_wr_q <= (state_q == WR_REQ) ||
                          (state_q == WR_RESP);
         end
`endif
      end
   end

endmodule
